// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that shares one 1-bit mux among N serial requesters.
// A requester holds the grant for up to MAX_BURST beats; beats go downstream over a valid/ready handshake.

module Generic_1bit_Mux #(
  parameter int INs = 2,
  parameter int SW  = (INs > 1) ? $clog2(INs) : 1
) (
  input  logic [INs-1:0] x,
  input  logic [SW-1:0]  sel,
  output logic           z
);
  always_comb begin
    z = 1'b0;
    for (int i = 0; i < INs; i++) begin
      if (int'(sel) == i) z = x[i];
    end
  end
endmodule

module rr_mux_arbiter #(
  parameter int N         = 5,
  parameter int SW        = (N > 1) ? $clog2(N) : 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  last,
  input  logic [N-1:0]  x,
  input  logic          out_ready,
  output logic [SW-1:0] sel,
  output logic [N-1:0]  gnt,
  output logic          z,
  output logic          z_valid,
  output logic          busy
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic          pick_found;
  logic [SW-1:0] pick_idx;
  logic          req_sel, last_sel, xfer, burst_end;

  // Scan starts just past the last-served requester, so it has lowest priority next round.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!pick_found && req[(int'(ptr_q) + k) % N]) begin
        pick_found = 1'b1;
        pick_idx   = SW'((int'(ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    req_sel  = 1'b0;
    last_sel = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel_q) == i) begin
        req_sel  = req[i];
        last_sel = last[i];
      end
    end
  end

  assign z_valid   = busy_q & req_sel;
  assign xfer      = z_valid & out_ready;
  // Dropping req abandons the burst; last and the cap together are still one end.
  assign burst_end = !req_sel || (xfer && (last_sel || cnt_q == CW'(MAX_BURST - 1)));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = N'(1) << pick_idx;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (xfer) cnt_d = cnt_q + CW'(1);
        if (burst_end) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= SW'(N - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  Generic_1bit_Mux #(.INs(N)) u_mux (
    .x   (x),
    .sel (sel_q),
    .z   (z)
  );

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=5, MAX_BURST=4) with hand-computed expectations.

module tb_rr_mux_arbiter;
  logic       clk, rst;
  logic [4:0] req, last, x;
  logic       out_ready;
  logic [2:0] sel;
  logic [4:0] gnt;
  logic       z, z_valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  rr_mux_arbiter #(.N(5), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .x         (x),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .z         (z),
    .z_valid   (z_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [4:0] e_gnt, input logic [2:0] e_sel,
                        input logic e_busy, input logic e_zv);
    chk({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    chk({tag, ".sel"},     32'(sel),     32'(e_sel));
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    chk({tag, ".z_valid"}, 32'(z_valid), 32'(e_zv));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; x = '0; out_ready = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    int order[5];
    order = '{0, 2, 4, 0, 2};

    rst = 1'b1; req = '0; last = '0; x = '0; out_ready = 1'b0;
    #3;
    chk_st("reset", 5'b00000, 3'd0, 1'b0, 1'b0);
    @(posedge clk); #3; rst = 1'b0;

    // 1: single requester, cap of 4 beats, one idle cycle, re-grant
    req = 5'b00001; out_ready = 1'b1; x = 5'b00001;
    tick(); chk_st("t1.grant", 5'b00001, 3'd0, 1'b1, 1'b1);
    chk("t1.z", 32'(z), 32'd1);
    tick(); chk_st("t1.beat2", 5'b00001, 3'd0, 1'b1, 1'b1);
    tick(); chk_st("t1.beat3", 5'b00001, 3'd0, 1'b1, 1'b1);
    tick(); chk_st("t1.beat4", 5'b00001, 3'd0, 1'b1, 1'b1);
    tick(); chk_st("t1.idle", 5'b00000, 3'd0, 1'b0, 1'b0);
    tick(); chk_st("t1.regrant", 5'b00001, 3'd0, 1'b1, 1'b1);

    // 2: round-robin 0,2,4,0,2 with 1-beat bursts
    do_reset();
    req = 5'b10101; last = 5'b11111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_st("t2.grant", 5'(32'd1 << order[i]), 3'(order[i]), 1'b1, 1'b1);
      tick();
      chk_st("t2.idle", 5'b00000, 3'(order[i]), 1'b0, 1'b0);
    end

    // 3: stall with out_ready=0, z tracks x[1], cnt holds
    do_reset();
    req = 5'b00010; x = 5'b00010; out_ready = 1'b0;
    tick(); chk_st("t3.grant", 5'b00010, 3'd1, 1'b1, 1'b1);
    chk("t3.z1", 32'(z), 32'd1);
    x = 5'b00000; #1; chk("t3.z0", 32'(z), 32'd0);
    tick(); chk_st("t3.stall1", 5'b00010, 3'd1, 1'b1, 1'b1);
    x = 5'b00010; #1; chk("t3.z1b", 32'(z), 32'd1);
    tick(); chk_st("t3.stall2", 5'b00010, 3'd1, 1'b1, 1'b1);
    x = 5'b00000; #1; chk("t3.z0b", 32'(z), 32'd0);
    tick(); chk_st("t3.stall3", 5'b00010, 3'd1, 1'b1, 1'b1);
    out_ready = 1'b1; x = 5'b00010;
    tick(); chk_st("t3.xfer1", 5'b00010, 3'd1, 1'b1, 1'b1);
    tick(); chk_st("t3.xfer2", 5'b00010, 3'd1, 1'b1, 1'b1);
    tick(); chk_st("t3.xfer3", 5'b00010, 3'd1, 1'b1, 1'b1);
    tick(); chk_st("t3.end", 5'b00000, 3'd1, 1'b0, 1'b0);

    // 4: requester 3 abandons after 2 transfers; pointer moves to 3
    do_reset();
    req = 5'b11000; out_ready = 1'b1;
    tick(); chk_st("t4.grant3", 5'b01000, 3'd3, 1'b1, 1'b1);
    tick(); chk_st("t4.beat2", 5'b01000, 3'd3, 1'b1, 1'b1);
    tick(); chk_st("t4.beat3", 5'b01000, 3'd3, 1'b1, 1'b1);
    req = 5'b10001; #1;
    chk("t4.zv_drop", 32'(z_valid), 32'd0);
    tick(); chk_st("t4.idle", 5'b00000, 3'd3, 1'b0, 1'b0);
    tick(); chk_st("t4.grant4", 5'b10000, 3'd4, 1'b1, 1'b1);

    // 5: asynchronous reset mid-burst
    do_reset();
    req = 5'b00100; x = 5'b00100; out_ready = 1'b1;
    tick(); chk_st("t5.grant2", 5'b00100, 3'd2, 1'b1, 1'b1);
    tick(); chk_st("t5.beat2", 5'b00100, 3'd2, 1'b1, 1'b1);
    #1; rst = 1'b1; #1;
    chk_st("t5.async_rst", 5'b00000, 3'd0, 1'b0, 1'b0);
    req = 5'b00110;
    @(posedge clk); #3; rst = 1'b0;
    tick(); chk_st("t5.lowest", 5'b00010, 3'd1, 1'b1, 1'b1);

    // 6: last coincides with the cap -> single idle cycle
    do_reset();
    req = 5'b00001; out_ready = 1'b1;
    tick(); chk_st("t6.grant", 5'b00001, 3'd0, 1'b1, 1'b1);
    tick(); tick(); tick();
    chk_st("t6.beat4", 5'b00001, 3'd0, 1'b1, 1'b1);
    last = 5'b00001;
    tick(); chk_st("t6.idle", 5'b00000, 3'd0, 1'b0, 1'b0);
    tick(); chk_st("t6.regrant", 5'b00001, 3'd0, 1'b1, 1'b1);
    tick(); chk_st("t6.cnt_cleared", 5'b00000, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
